fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Parametrised streaming frame loader that sits in front of the first-stage parallel FFT of the two-dimensional FFT datapath, replacing the fixed 64-point serial input buffer and its input counter. It accepts one complex sample per cycle over a valid/ready handshake and assembles NPT-sample frames in a ping-pong buffer. It then emits each frame as NPT/RADIX beats of RADIX parallel lanes in stride order, ready for the first-stage RADIX-point butterflies. Per-frame FFT/IFFT mode is latched with the frame, and back-pressure is supported on both sides.

## Interface
- DATA_W, 16: bits per real/imag component; a complex word is 2*DATA_W bits, {re, im}.
- NPT, 64: points per frame; power of two, ≥ RADIX.
- RADIX, 8: parallel output lanes; power of two; NPT % RADIX == 0.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = FFT, 1 = IFFT; sampled on the first accepted sample of each frame.
- s_data  in  2*DATA_W  input complex sample {re, im}.
- s_valid  in  1  input sample valid.
- s_last  in  1  framing marker; expected high on sample NPT-1 only.
- s_ready  out  1  loader can accept a sample this cycle.
- m_data  out  RADIX*2*DATA_W  lane l in bits [(l+1)*2*DATA_W-1 : l*2*DATA_W].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_first  out  1  current beat is beat 0 of a frame.
- m_last  out  1  current beat is beat NPT/RADIX-1 of a frame.
- m_mode  out  1  latched mode of the frame being read.
- err_frame  out  1  one-cycle pulse on an s_last mismatch.

## Operation
- Two banks, each holding NPT complex words plus a full flag and a latched mode bit. The write side uses wr_bank and wr_cnt (log2 NPT bits). The read side uses rd_bank and rd_cnt (log2(NPT/RADIX) bits).
- Write: s_ready = !rst && !full[wr_bank]. When s_valid && s_ready:
  - store the sample at index wr_cnt of wr_bank;
  - when IFFT mode applies, store it with re/im swapped (IFFT by swap trick; output swap is handled downstream);
  - on wr_cnt == 0, latch mode into the bank's mode bit, and that value governs the swap for the whole frame;
  - on wr_cnt == NPT-1, set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0. Otherwise wr_cnt increments.
- Framing is count-based only. err_frame pulses in the cycle after acceptance when s_last is high with wr_cnt != NPT-1, or low with wr_cnt == NPT-1. The frame completes regardless of the error.
- Read: m_valid = full[rd_bank]. Beat k = rd_cnt; lane l carries sample index l*(NPT/RADIX) + k.
  - On m_valid && m_ready, rd_cnt increments.
  - On the last beat, full[rd_bank] clears, rd_bank toggles and rd_cnt wraps to 0.
- m_first = m_valid && rd_cnt == 0. m_last = m_valid && rd_cnt == NPT/RADIX-1. m_mode = mode bit of rd_bank.
- m_data, m_first, m_last and m_mode stay stable while m_valid && !m_ready.
- Simultaneous events:
  - A write completing into one bank and a read freeing the other bank in the same cycle are both honoured.
  - A bank freed by the read side is writable the next cycle; no combinational ready-to-ready path exists.
- Both banks full: s_ready is low and input stalls. No sample is ever overwritten or dropped.

## Timing
- Reset: wr_bank, rd_bank, wr_cnt, rd_cnt, full[] and mode bits are all 0. s_ready, m_valid, m_first, m_last, m_mode and err_frame are 0. m_data is don't-care but registered storage is not required to clear.
- s_ready rises in the first cycle after rst deasserts.
- Reset mid-frame discards all partial and full frames.
- Latency: the last sample of a frame accepted at edge t gives m_valid = 1 in the cycle after t, i.e. one cycle from frame completion to first beat.
- Throughput: with m_ready held high, a frame drains in NPT/RADIX cycles. The input then sustains 1 sample/cycle indefinitely, because the ping-pong swap absorbs the frame boundary.
- err_frame is a registered single-cycle pulse.

## Structure
- Shared package fft_pkg holds:
  - the complex-word width helper (CW = 2*DATA_W);
  - the clog2 function;
  - mode encodings FFT_MODE = 0 and IFFT_MODE = 1.
- Sub-module fft_frame_bank: one bank containing the storage array, write port, full flag, mode bit and strided RADIX-lane read mux. It is instantiated twice.
- The top level holds the pointers, handshake logic and framing check.

## Test plan
- NPT=64, RADIX=8; stream samples re=n, im=0 for n=0..63 with m_ready=1 -> 8 beats; beat k lane l = {8l+k, 0}; m_first on beat 0, m_last on beat 7, err_frame never high.
- mode=1 on sample 0 then mode=0 mid-frame, samples {re=n, im=100+n} -> whole frame swapped: beat 0 lane 1 = {108, 8}; m_mode=1 for all 8 beats.
- m_ready=0 throughout, 3 frames offered -> 128 samples accepted; s_ready drops after sample 127; m_data frozen on frame 0 beat 0. Releasing m_ready -> frame 0 then frame 1 emitted intact, then frame 2 accepted.
- s_last asserted on sample 10 and absent on sample 63 -> two err_frame pulses; frame still emitted as 8 correct beats.
- rst asserted for 1 cycle after sample 30 -> all outputs 0 next cycle; a fresh 64-sample frame is output starting at lane 0 = sample 0 with no stale data.
- Parameter sweep NPT=16, RADIX=4, DATA_W=12, with random s_valid/m_ready throttling -> output matches a reference stride-reorder model for 100 frames.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the 2-D FFT datapath front end.
//   cw()    - complex-word width for a given component width ({re, im}).
//   clog2() - ceiling log2 for parameter arithmetic.
//   FFT_MODE / IFFT_MODE - per-frame transform direction encodings.
package fft_pkg;

  localparam logic FFT_MODE  = 1'b0;
  localparam logic IFFT_MODE = 1'b1;

  function automatic int cw(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample-in / beat-out handshake bundle of the frame loader.
//   mode, s_data, s_valid, s_last, s_ready : one complex sample per cycle in.
//   m_data, m_valid, m_ready, m_first, m_last, m_mode : RADIX-lane beats out.
// master = environment around the loader (source + sink), slave = the loader.
interface fft_frame_loader_if
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RADIX  = 8
);
  localparam int CW = cw(DATA_W);

  logic                  mode;
  logic [CW-1:0]         s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [RADIX*CW-1:0]   m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_first;
  logic                  m_last;
  logic                  m_mode;

  modport master (
    output mode, s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_first, m_last, m_mode
  );

  modport slave (
    input  mode, s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_first, m_last, m_mode
  );
endinterface

// File: rtl/fft_frame_loader_bank.sv
// fft_frame_bank: one half of the ping-pong frame buffer.
//   clk, rst   - clock, synchronous active-high reset (full flag and mode bit).
//   wr_en      - store wr_data at wr_addr; address NPT-1 marks the bank full.
//   wr_mode    - live mode input; latched at address 0 and used for the frame.
//   clr_full   - read side has consumed the last beat of this bank.
//   rd_beat    - beat index k; lane l returns sample l*(NPT/RADIX)+k.
//   full, mode_bit, rd_data - bank status and strided RADIX-lane read data.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NPT    = 64,
  parameter  int RADIX  = 8,
  localparam int CW     = cw(DATA_W),
  localparam int AW     = clog2(NPT),
  localparam int NB     = NPT / RADIX,
  localparam int BW     = (NB > 1) ? clog2(NB) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW-1:0]       wr_data,
  input  logic                wr_mode,
  input  logic                clr_full,
  input  logic [BW-1:0]       rd_beat,
  output logic                full,
  output logic                mode_bit,
  output logic [RADIX*CW-1:0] rd_data
);

  logic [CW-1:0] mem [NPT];
  logic          eff_mode;
  logic [CW-1:0] store_word;

  // Sample 0 sees the live mode; the rest of the frame follows the latched bit.
  assign eff_mode   = (wr_addr == '0) ? wr_mode : mode_bit;
  // IFFT via the swap trick: re/im exchanged on the way in.
  assign store_word = (eff_mode == IFFT_MODE) ? {wr_data[DATA_W-1:0], wr_data[CW-1:DATA_W]}
                                              : wr_data;

  // NOTE: storage has no reset; the full flag alone decides whether contents are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= store_word;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      mode_bit <= FFT_MODE;
    end else begin
      // A bank is never written and drained at once (write needs !full, read needs full).
      if (wr_en && wr_addr == AW'(NPT - 1)) full <= 1'b1;
      else if (clr_full)                    full <= 1'b0;
      if (wr_en && wr_addr == '0) mode_bit <= wr_mode;
    end
  end

  for (genvar l = 0; l < RADIX; l++) begin : g_lane
    assign rd_data[l*CW +: CW] = mem[AW'(l * NB) + AW'(rd_beat)];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: streaming ping-pong frame loader for the first FFT stage.
//   clk, rst  - clock, synchronous active-high reset.
//   bus       - fft_frame_loader_if.slave: serial complex samples in, frames out
//               as NPT/RADIX beats of RADIX lanes in stride order.
//   err_frame - registered one-cycle pulse when s_last disagrees with the count.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NPT    = 64,
  parameter  int RADIX  = 8,
  localparam int CW     = cw(DATA_W),
  localparam int AW     = clog2(NPT),
  localparam int NB     = NPT / RADIX,
  localparam int BW     = (NB > 1) ? clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  fft_frame_loader_if.slave bus,
  output logic          err_frame
);

  logic                wr_bank;
  logic                rd_bank;
  logic [AW-1:0]       wr_cnt;
  logic [BW-1:0]       rd_cnt;
  logic [1:0]          full;
  logic [1:0]          mode_q;
  logic [RADIX*CW-1:0] rd_data [2];

  logic s_ready;
  logic m_valid;
  logic wr_fire;
  logic wr_end;
  logic rd_fire;
  logic rd_end;

  // Ready depends only on registered state, so there is no m_ready -> s_ready path.
  assign s_ready = !rst && !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign wr_fire = bus.s_valid && s_ready;
  assign wr_end  = (wr_cnt == AW'(NPT - 1));
  assign rd_fire = m_valid && bus.m_ready;
  assign rd_end  = (rd_cnt == BW'(NB - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .DATA_W (DATA_W),
      .NPT    (NPT),
      .RADIX  (RADIX)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_fire && wr_bank == 1'(b)),
      .wr_addr  (wr_cnt),
      .wr_data  (bus.s_data),
      .wr_mode  (bus.mode),
      .clr_full (rd_fire && rd_end && rd_bank == 1'(b)),
      .rd_beat  (rd_cnt),
      .full     (full[b]),
      .mode_bit (mode_q[b]),
      .rd_data  (rd_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      err_frame <= 1'b0;
    end else begin
      // Framing is count-based; a bad s_last only flags, it never shortens a frame.
      err_frame <= wr_fire && (bus.s_last != wr_end);

      if (wr_fire) begin
        if (wr_end) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end

      if (rd_fire) begin
        if (rd_end) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Storage of a full bank is frozen, so these hold steady under back-pressure.
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = rd_data[rd_bank];
  assign bus.m_first = m_valid && (rd_cnt == '0);
  assign bus.m_last  = m_valid && rd_end;
  assign bus.m_mode  = mode_q[rd_bank];

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

  // Instance A: NPT=64, RADIX=8, DATA_W=16.  Instance B: NPT=16, RADIX=4, DATA_W=12.
  typedef struct { logic [31:0]  d; logic last; logic mode; } samp_a_t;
  typedef struct { logic [255:0] d; logic first; logic last; logic mode; int step; } beat_a_t;
  typedef struct { logic [23:0]  d; logic last; logic mode; } samp_b_t;
  typedef struct { logic [95:0]  d; logic first; logic last; logic mode; } beat_b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_err;
  logic b_err;

  int total = 0;
  int bad   = 0;

  samp_a_t a_in[$];
  beat_a_t a_out[$];
  samp_b_t b_in[$];
  beat_b_t b_out[$];
  int a_acc = 0;
  int a_step = 0;
  int a_end_step = -1;
  int a_err_cnt = 0;
  int b_err_cnt = 0;

  always #5 clk = ~clk;

  fft_frame_loader_if #(.DATA_W(16), .RADIX(8)) a_bus ();
  fft_frame_loader_if #(.DATA_W(12), .RADIX(4)) b_bus ();

  fft_frame_loader #(.DATA_W(16), .NPT(64), .RADIX(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (a_bus),
    .err_frame (a_err)
  );

  fft_frame_loader #(.DATA_W(12), .NPT(16), .RADIX(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (b_bus),
    .err_frame (b_err)
  );

  always @(negedge clk) begin
    if (a_err === 1'b1) a_err_cnt++;
    if (b_err === 1'b1) b_err_cnt++;
  end

  // One cycle on instance A: drive inputs, record what the coming edge transfers.
  task automatic step_a(input logic rdy);
    beat_a_t bt;
    a_bus.m_ready = rdy;
    if (a_in.size() != 0) begin
      a_bus.s_valid = 1'b1;
      a_bus.s_data  = a_in[0].d;
      a_bus.s_last  = a_in[0].last;
      a_bus.mode    = a_in[0].mode;
    end else begin
      a_bus.s_valid = 1'b0;
      a_bus.s_data  = '0;
      a_bus.s_last  = 1'b0;
      a_bus.mode    = 1'b0;
    end
    #1;
    if (a_bus.s_valid && a_bus.s_ready === 1'b1) begin
      void'(a_in.pop_front());
      a_acc++;
      if (a_acc % 64 == 0) a_end_step = a_step;
    end
    if (a_bus.m_valid === 1'b1 && rdy) begin
      bt.d = a_bus.m_data; bt.first = a_bus.m_first; bt.last = a_bus.m_last;
      bt.mode = a_bus.m_mode; bt.step = a_step;
      a_out.push_back(bt);
    end
    @(negedge clk);
    a_step++;
  endtask

  task automatic step_b(input logic vld_en, input logic rdy);
    beat_b_t bt;
    b_bus.m_ready = rdy;
    if (b_in.size() != 0 && vld_en) begin
      b_bus.s_valid = 1'b1;
      b_bus.s_data  = b_in[0].d;
      b_bus.s_last  = b_in[0].last;
      b_bus.mode    = b_in[0].mode;
    end else begin
      b_bus.s_valid = 1'b0;
      b_bus.s_data  = '0;
      b_bus.s_last  = 1'b0;
      b_bus.mode    = 1'b0;
    end
    #1;
    if (b_bus.s_valid && b_bus.s_ready === 1'b1) void'(b_in.pop_front());
    if (b_bus.m_valid === 1'b1 && rdy) begin
      bt.d = b_bus.m_data; bt.first = b_bus.m_first; bt.last = b_bus.m_last;
      bt.mode = b_bus.m_mode;
      b_out.push_back(bt);
    end
    @(negedge clk);
  endtask

  task automatic push_a(input logic [31:0] d, input logic last, input logic mode);
    samp_a_t s;
    s.d = d; s.last = last; s.mode = mode;
    a_in.push_back(s);
  endtask

  task automatic drain_a(input int beats, input int budget);
    int n;
    n = 0;
    while (a_out.size() < beats && n < budget) begin
      step_a(1'b1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (a_bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready_in_rst: got %b want 0", a_bus.s_ready); end
    total++; if (a_bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", a_bus.m_valid); end
    total++; if ({a_bus.m_first, a_bus.m_last, a_bus.m_mode, a_err} !== 4'b0)
      begin bad++; $display("FAIL reset_flags: got %b want 0000", {a_bus.m_first, a_bus.m_last, a_bus.m_mode, a_err}); end
    rst = 1'b0;
    a_acc = 0;
    #1;
    total++; if (a_bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready_after: got %b want 1", a_bus.s_ready); end
    total++; if (b_bus.s_ready !== 1'b1 || b_bus.m_valid !== 1'b0)
      begin bad++; $display("FAIL reset_b_ready_valid: got %b%b want 10", b_bus.s_ready, b_bus.m_valid); end
  endtask

  task automatic test_basic();
    logic [31:0]  fr [64];
    logic [255:0] exp;
    int err0;
    err0 = a_err_cnt;
    a_out.delete();
    for (int i = 0; i < 64; i++) begin
      fr[i] = {16'(i), 16'd0};
      push_a(fr[i], i == 63, 1'b0);
    end
    drain_a(8, 200);
    step_a(1'b1);
    total++; if (a_out.size() != 8) begin bad++; $display("FAIL basic_beats: got %0d want 8", a_out.size()); end
    for (int k = 0; k < 8 && k < a_out.size(); k++) begin
      exp = '0;
      for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[l*8 + k];
      total++; if (a_out[k].d !== exp) begin bad++; $display("FAIL basic_data beat%0d: got %h want %h", k, a_out[k].d, exp); end
      total++; if ({a_out[k].first, a_out[k].last, a_out[k].mode} !== {k == 0, k == 7, 1'b0})
        begin bad++; $display("FAIL basic_flags beat%0d: got %b want %b", k, {a_out[k].first, a_out[k].last, a_out[k].mode}, {k == 0, k == 7, 1'b0}); end
    end
    if (a_out.size() == 8) begin
      total++; if (a_out[0].step != a_end_step + 1) begin bad++; $display("FAIL basic_latency: got step %0d want %0d", a_out[0].step, a_end_step + 1); end
      total++; if (a_out[7].step != a_out[0].step + 7) begin bad++; $display("FAIL basic_drain: got %0d want %0d", a_out[7].step - a_out[0].step, 7); end
    end
    total++; if (a_err_cnt != err0) begin bad++; $display("FAIL basic_err: got %0d pulses want 0", a_err_cnt - err0); end
  endtask

  task automatic test_ifft_mode();
    logic [31:0]  fr [64];
    logic [255:0] exp;
    a_out.delete();
    for (int i = 0; i < 64; i++) begin
      fr[i] = {16'(100 + i), 16'(i)};
      push_a({16'(i), 16'(100 + i)}, i == 63, i == 0);
    end
    drain_a(8, 200);
    total++; if (a_out.size() != 8) begin bad++; $display("FAIL ifft_beats: got %0d want 8", a_out.size()); end
    if (a_out.size() != 0) begin
      total++; if (a_out[0].d[63:32] !== {16'd108, 16'd8}) begin bad++; $display("FAIL ifft_b0_lane1: got %h want %h", a_out[0].d[63:32], {16'd108, 16'd8}); end
    end
    for (int k = 0; k < 8 && k < a_out.size(); k++) begin
      exp = '0;
      for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[l*8 + k];
      total++; if (a_out[k].d !== exp) begin bad++; $display("FAIL ifft_data beat%0d: got %h want %h", k, a_out[k].d, exp); end
      total++; if (a_out[k].mode !== 1'b1) begin bad++; $display("FAIL ifft_m_mode beat%0d: got %b want 1", k, a_out[k].mode); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]  fr [3][64];
    logic [255:0] exp;
    int acc0;
    a_out.delete();
    acc0 = a_acc;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) begin
        fr[f][i] = {16'(f * 64 + i), 16'(f)};
        push_a(fr[f][i], i == 63, 1'b0);
      end
    exp = '0;
    for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[0][l*8];
    repeat (150) step_a(1'b0);
    total++; if (a_bus.m_data !== exp) begin bad++; $display("FAIL bp_frozen_early: got %h want %h", a_bus.m_data, exp); end
    repeat (50) step_a(1'b0);
    total++; if (a_acc - acc0 != 128) begin bad++; $display("FAIL bp_accepted: got %0d want 128", a_acc - acc0); end
    total++; if (a_bus.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready: got %b want 0", a_bus.s_ready); end
    total++; if (a_bus.m_valid !== 1'b1 || a_bus.m_first !== 1'b1)
      begin bad++; $display("FAIL bp_valid_first: got %b%b want 11", a_bus.m_valid, a_bus.m_first); end
    total++; if (a_bus.m_data !== exp) begin bad++; $display("FAIL bp_frozen_late: got %h want %h", a_bus.m_data, exp); end
    drain_a(24, 300);
    total++; if (a_out.size() != 24) begin bad++; $display("FAIL bp_beats: got %0d want 24", a_out.size()); end
    for (int j = 0; j < 24 && j < a_out.size(); j++) begin
      exp = '0;
      for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[j / 8][l*8 + (j % 8)];
      total++; if (a_out[j].d !== exp) begin bad++; $display("FAIL bp_data beat%0d: got %h want %h", j, a_out[j].d, exp); end
      total++; if ({a_out[j].first, a_out[j].last} !== {j % 8 == 0, j % 8 == 7})
        begin bad++; $display("FAIL bp_flags beat%0d: got %b want %b", j, {a_out[j].first, a_out[j].last}, {j % 8 == 0, j % 8 == 7}); end
    end
    total++; if (a_in.size() != 0) begin bad++; $display("FAIL bp_input_left: got %0d want 0", a_in.size()); end
  endtask

  task automatic test_framing_error();
    logic [31:0]  fr [64];
    logic [255:0] exp;
    int err0;
    err0 = a_err_cnt;
    a_out.delete();
    for (int i = 0; i < 64; i++) begin
      fr[i] = {16'(200 + i), 16'(i)};
      push_a(fr[i], i == 10, 1'b0);
    end
    drain_a(8, 200);
    repeat (2) step_a(1'b1);
    total++; if (a_err_cnt - err0 != 2) begin bad++; $display("FAIL ferr_pulses: got %0d want 2", a_err_cnt - err0); end
    total++; if (a_out.size() != 8) begin bad++; $display("FAIL ferr_beats: got %0d want 8", a_out.size()); end
    for (int k = 0; k < 8 && k < a_out.size(); k++) begin
      exp = '0;
      for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[l*8 + k];
      total++; if (a_out[k].d !== exp) begin bad++; $display("FAIL ferr_data beat%0d: got %h want %h", k, a_out[k].d, exp); end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0]  fr [64];
    logic [255:0] exp;
    a_out.delete();
    for (int i = 0; i < 31; i++) push_a({16'(300 + i), 16'd9}, 1'b0, i == 0);
    repeat (40) step_a(1'b1);
    a_in.delete();
    a_bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++; if ({a_bus.s_ready, a_bus.m_valid, a_bus.m_first, a_bus.m_last, a_bus.m_mode, a_err} !== 6'b0)
      begin bad++; $display("FAIL mrst_outputs: got %b want 000000", {a_bus.s_ready, a_bus.m_valid, a_bus.m_first, a_bus.m_last, a_bus.m_mode, a_err}); end
    rst = 1'b0;
    a_acc = 0;
    a_out.delete();
    for (int i = 0; i < 64; i++) begin
      fr[i] = {16'(400 + i), 16'(i)};
      push_a(fr[i], i == 63, 1'b0);
    end
    drain_a(8, 200);
    total++; if (a_out.size() != 8) begin bad++; $display("FAIL mrst_beats: got %0d want 8", a_out.size()); end
    for (int k = 0; k < 8 && k < a_out.size(); k++) begin
      exp = '0;
      for (int l = 0; l < 8; l++) exp[l*32 +: 32] = fr[l*8 + k];
      total++; if (a_out[k].d !== exp) begin bad++; $display("FAIL mrst_data beat%0d: got %h want %h", k, a_out[k].d, exp); end
      total++; if ({a_out[k].first, a_out[k].mode} !== {k == 0, 1'b0})
        begin bad++; $display("FAIL mrst_flags beat%0d: got %b want %b", k, {a_out[k].first, a_out[k].mode}, {k == 0, 1'b0}); end
    end
  endtask

  // Random throttling on the small instance against a stride-reorder model.
  task automatic test_sweep();
    logic [23:0] smp [16];
    logic [23:0] w;
    logic        fm;
    beat_b_t     e;
    beat_b_t     exq[$];
    samp_b_t     s;
    int n;
    int err0;
    err0 = b_err_cnt;
    b_out.delete();
    for (int f = 0; f < 100; f++) begin
      fm = 1'($urandom_range(1, 0));
      for (int i = 0; i < 16; i++) begin
        smp[i] = 24'($urandom);
        s.d = smp[i]; s.last = (i == 15);
        s.mode = (i == 0) ? fm : 1'($urandom_range(1, 0));
        b_in.push_back(s);
      end
      for (int k = 0; k < 4; k++) begin
        e.d = '0;
        for (int l = 0; l < 4; l++) begin
          w = smp[l*4 + k];
          if (fm) w = {w[11:0], w[23:12]};
          e.d[l*24 +: 24] = w;
        end
        e.first = (k == 0); e.last = (k == 3); e.mode = fm;
        exq.push_back(e);
      end
    end
    n = 0;
    while (b_out.size() < 400 && n < 20000) begin
      step_b($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
      n++;
    end
    total++; if (b_out.size() != 400) begin bad++; $display("FAIL sweep_beats: got %0d want 400", b_out.size()); end
    for (int j = 0; j < 400 && j < b_out.size(); j++) begin
      total++;
      if (b_out[j].d !== exq[j].d || b_out[j].first !== exq[j].first ||
          b_out[j].last !== exq[j].last || b_out[j].mode !== exq[j].mode) begin
        bad++;
        $display("FAIL sweep_beat%0d: got %h/%b%b%b want %h/%b%b%b", j, b_out[j].d, b_out[j].first,
                 b_out[j].last, b_out[j].mode, exq[j].d, exq[j].first, exq[j].last, exq[j].mode);
      end
    end
    total++; if (b_err_cnt != err0) begin bad++; $display("FAIL sweep_err: got %0d pulses want 0", b_err_cnt - err0); end
  endtask

  initial begin
    a_bus.mode = 1'b0; a_bus.s_data = '0; a_bus.s_valid = 1'b0; a_bus.s_last = 1'b0; a_bus.m_ready = 1'b0;
    b_bus.mode = 1'b0; b_bus.s_data = '0; b_bus.s_valid = 1'b0; b_bus.s_last = 1'b0; b_bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_ifft_mode();
    test_backpressure();
    test_framing_error();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
